// File: rtl/config_controller_if.sv
// Handshake/status bundle between a configuration source and config_controller.
// The source owns start/abort/in_*; the controller owns in_ready, cfg_* and status.
interface config_controller_if #(
  parameter int CFG_W = 5,
  parameter int IDX_W = 2
);
  // Frame handshake: a frame moves on a rising clk edge where in_valid and
  // in_ready are both 1; in_data/in_parity must be stable while in_valid is
  // high, and the source may drop in_valid at any time without penalty.
  logic             start;
  logic             abort;
  logic             in_valid;
  logic [CFG_W-1:0] in_data;
  logic             in_parity;
  logic             in_ready;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_shift;
  logic [IDX_W-1:0] block_idx;
  logic             busy;
  logic             done;
  logic             error;
  logic [2:0]       dbg_state;

  modport master (
    output start, abort, in_valid, in_data, in_parity,
    input  in_ready, cfg_data, cfg_shift, block_idx, busy, done, error, dbg_state
  );

  modport slave (
    input  start, abort, in_valid, in_data, in_parity,
    output in_ready, cfg_data, cfg_shift, block_idx, busy, done, error, dbg_state
  );
endinterface

// File: rtl/config_controller.sv
// Loads NUM_BLOCKS frames into a configuration shift chain, last block first.
// Define CFG_PARITY_EN to check even parity per frame and trap bad frames in ERROR.
module config_controller #(
  parameter int NUM_BLOCKS    = 4,
  parameter int CFG_W         = 5,
  parameter int SETTLE_CYCLES = 2,
  localparam int IDX_W = $clog2(NUM_BLOCKS)
) (
  input logic                clk,
  input logic                reset,
  config_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_cnt;
  logic [3:0]       r_settle;
  logic             r_in_ready;
  logic [CFG_W-1:0] r_cfg_data;
  logic             r_cfg_shift;
  logic [IDX_W-1:0] r_block_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic w_xfer, w_par_ok, w_last, w_start;
  logic w_in_ready, w_busy, w_done, w_error, w_cfg_shift;

  // abort wins over everything, including a frame offered in the same cycle
  assign w_xfer  = (r_state == S_LOAD) && r_in_ready && bus.in_valid && !bus.abort;
  assign w_last  = (r_cnt == IDX_W'(NUM_BLOCKS - 1));
  assign w_start = bus.start && !bus.abort;

`ifdef CFG_PARITY_EN
  assign w_par_ok = ~(^{bus.in_data, bus.in_parity});
`else
  logic w_unused_parity;
  assign w_unused_parity = bus.in_parity;
  assign w_par_ok        = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_LOAD;
      S_LOAD: begin
        if (bus.abort)                w_next = S_IDLE;
        else if (w_xfer && !w_par_ok) w_next = S_ERROR;
        else if (w_xfer && w_last)    w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (bus.abort)                             w_next = S_IDLE;
        else if (r_settle == 4'(SETTLE_CYCLES))    w_next = S_DONE;
      end
      S_DONE:   if (w_start) w_next = S_LOAD;
      S_ERROR:  if (w_start) w_next = S_LOAD;
      default:  w_next = S_IDLE;
    endcase
  end

  // Status is decoded from the next state so the registered flags track r_state.
  always_comb begin
    w_in_ready  = (w_next == S_LOAD);
    w_busy      = (w_next == S_LOAD) || (w_next == S_SETTLE);
    w_done      = (w_next == S_DONE);
    w_cfg_shift = w_xfer && w_par_ok;
`ifdef CFG_PARITY_EN
    w_error     = (w_next == S_ERROR);
`else
    w_error     = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_settle    <= '0;
      r_in_ready  <= 1'b0;
      r_cfg_data  <= '0;
      r_cfg_shift <= 1'b0;
      r_block_idx <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_next == S_LOAD && r_state != S_LOAD) r_cnt <= '0;
      else if (w_cfg_shift && !w_last)           r_cnt <= r_cnt + 1'b1;
      // the first SETTLE cycle is the final shift cycle; idle cycles follow
      if (r_state != S_SETTLE) r_settle <= '0;
      else                     r_settle <= r_settle + 1'b1;
      if (w_cfg_shift) begin
        r_cfg_data  <= bus.in_data;
        r_block_idx <= IDX_W'(NUM_BLOCKS - 1) - r_cnt;
      end
      r_in_ready  <= w_in_ready;
      r_cfg_shift <= w_cfg_shift;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_error     <= w_error;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.cfg_data  = r_cfg_data;
  assign bus.cfg_shift = r_cfg_shift;
  assign bus.block_idx = r_block_idx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.dbg_state = r_state;

endmodule
